// File: rtl/led_owner_arb.sv
// LED / key ownership arbiter between EMPU GPIO and the pattern generator.
// Debounces the key, runs the patterns and guards every ownership change.
module led_owner_arb #(
   parameter int unsigned DEBOUNCE_CYC = 540000,
   parameter int unsigned LONG_CYC     = 54000000,
   parameter int unsigned BLINK_CYC    = 13500000
) (
   input  logic        sys_clk_i,
   input  logic        reset_i,
   input  logic        key_i,
   input  logic [15:0] cpu_gpioout_i,
   input  logic [15:0] cpu_gpioouten_i,
   input  logic        cpu_req_i,
   output logic        key_gpio_o,
   output logic        key_evt_o,
   output logic [2:0]  led_o,
   output logic        led_en_o,
   output logic        owner_o,
   output logic [1:0]  mode_o
);

   localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int HL_W = $clog2(LONG_CYC + 1);
   localparam int BK_W = $clog2(BLINK_CYC + 1);

   typedef enum logic [2:0] {
      ST_HW,
      ST_G2C,
      ST_CPU,
      ST_G2H,
      ST_LOCK
   } state_t;

   state_t          state;
   logic            lockout;
   logic            sync1;
   logic            sync2;
   logic            key_db;
   logic [DB_W-1:0] db_cnt;
   logic [HL_W-1:0] hold_cnt;
   logic            long_evt;
   logic            short_evt;
   logic [BK_W-1:0] tick_cnt;
   logic [2:0]      pat;
   logic [2:0]      pat_step;
   logic [2:0]      pat_first;
   logic [1:0]      mode_nxt;
   logic            db_flip;
   logic            db_rel;
   logic            claim;
   logic            adv;
   logic            tick;
   logic            unused_hi;

   assign unused_hi = ^{cpu_gpioout_i[15:3], cpu_gpioouten_i[15:3]};

   assign key_gpio_o = key_db;
   assign db_flip    = (sync2 != key_db) &&
                       (db_cnt == DB_W'(DEBOUNCE_CYC - 1));
   assign db_rel     = db_flip && !key_db;
   assign claim      = cpu_req_i && (cpu_gpioouten_i[2:0] == 3'b111);
   assign adv        = short_evt &&
                       (((state == ST_HW) && !claim) || (state == ST_LOCK));
   assign tick       = (tick_cnt == BK_W'(BLINK_CYC - 1));
   assign mode_nxt   = mode_o + 2'd1;
   assign pat_first  = (mode_nxt == 2'd2) ? 3'b001 : 3'b000;

   // Next pattern value on a tick for the current mode.
   always_comb begin
      pat_step = pat;
      unique case (mode_o)
         2'd0:    pat_step = 3'b000;
         2'd1:    pat_step = ~pat;
         2'd2:    pat_step = {pat[1:0], pat[2]};
         default: pat_step = pat + 3'd1;
      endcase
   end

   // Synchronize the raw key and accept a level only after it is stable.
   always_ff @(posedge sys_clk_i) begin
      if (reset_i) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         key_db    <= 1'b1;
         db_cnt    <= '0;
         key_evt_o <= 1'b0;
      end else begin
         sync1     <= key_i;
         sync2     <= sync1;
         key_evt_o <= db_flip && key_db;
         if (db_flip) begin
            key_db <= sync2;
            db_cnt <= '0;
         end else if (sync2 != key_db) begin
            db_cnt <= db_cnt + 1'b1;
         end else begin
            db_cnt <= '0;
         end
      end
   end

   // Measure press length; classify as short on release or long at limit.
   always_ff @(posedge sys_clk_i) begin
      if (reset_i) begin
         hold_cnt  <= '0;
         long_evt  <= 1'b0;
         short_evt <= 1'b0;
      end else begin
         long_evt  <= !key_db && !db_rel &&
                      (hold_cnt == HL_W'(LONG_CYC - 1));
         short_evt <= db_rel && (hold_cnt < HL_W'(LONG_CYC));
         if (db_rel) begin
            hold_cnt <= '0;
         end else if (!key_db && (hold_cnt != HL_W'(LONG_CYC))) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

   // Mode selection and pattern stepping; a mode change restarts the step.
   always_ff @(posedge sys_clk_i) begin
      if (reset_i) begin
         mode_o   <= 2'd0;
         tick_cnt <= '0;
         pat      <= 3'b000;
      end else if (adv) begin
         mode_o   <= mode_nxt;
         tick_cnt <= '0;
         pat      <= pat_first;
      end else if (tick) begin
         tick_cnt <= '0;
         pat      <= pat_step;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Ownership FSM with a blank LED cycle on every hand-over.
   always_ff @(posedge sys_clk_i) begin
      if (reset_i) begin
         state    <= ST_HW;
         lockout  <= 1'b0;
         led_o    <= 3'b000;
         owner_o  <= 1'b0;
         led_en_o <= 1'b1;
      end else begin
         led_en_o <= 1'b0;
         case (state)
            ST_HW: begin
               owner_o <= 1'b0;
               if (claim) begin
                  state <= ST_G2C;
                  led_o <= 3'b000;
               end else begin
                  led_o <= pat;
               end
            end
            ST_G2C: begin
               state   <= ST_CPU;
               owner_o <= 1'b1;
               led_o   <= cpu_gpioout_i[2:0];
            end
            ST_CPU: begin
               if (long_evt || !claim) begin
                  state   <= ST_G2H;
                  lockout <= long_evt;
                  owner_o <= 1'b0;
                  led_o   <= 3'b000;
               end else begin
                  owner_o <= 1'b1;
                  led_o   <= cpu_gpioout_i[2:0];
               end
            end
            ST_G2H: begin
               state   <= lockout ? ST_LOCK : ST_HW;
               owner_o <= 1'b0;
               led_o   <= pat;
            end
            ST_LOCK: begin
               owner_o <= 1'b0;
               led_o   <= pat;
               if (!cpu_req_i) state <= ST_HW;
            end
            default: begin
               state   <= ST_HW;
               owner_o <= 1'b0;
               led_o   <= 3'b000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_owner_arb.sv
// Testbench for led_owner_arb.
// Scenario tasks plus random traffic against a cycle-level reference model.
module tb_led_owner_arb;

   localparam int D = 4;
   localparam int L = 20;
   localparam int B = 8;
   localparam int P_HW = 0, P_TOC = 1, P_CPU = 2, P_TOH = 3, P_LOCK = 4;
   localparam logic [8:0] RST_VEC = 9'b1_0_000_1_0_00;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key = 1'b1;
   logic        req = 1'b0;
   logic [15:0] gpio = 16'h0000;
   logic [15:0] ouen = 16'h0000;
   logic        key_gpio;
   logic        key_evt;
   logic [2:0]  led;
   logic        led_en;
   logic        owner;
   logic [1:0]  mode;

   int n_checks = 0;
   int n_errs = 0;

   int m_h1, m_h2, m_db, m_run, m_evt, m_hold, m_long, m_short;
   int m_mode, m_since, m_phase, m_lock, m_led, m_owner, m_en;

   always #5 clk = ~clk;

   led_owner_arb #(
      .DEBOUNCE_CYC(D),
      .LONG_CYC(L),
      .BLINK_CYC(B)
   ) dut (
      .sys_clk_i(clk),
      .reset_i(rst),
      .key_i(key),
      .cpu_gpioout_i(gpio),
      .cpu_gpioouten_i(ouen),
      .cpu_req_i(req),
      .key_gpio_o(key_gpio),
      .key_evt_o(key_evt),
      .led_o(led),
      .led_en_o(led_en),
      .owner_o(owner),
      .mode_o(mode)
   );

   // Pattern after k ticks in mode md.
   function automatic int pat_of(int md, int k);
      case (md)
         0: return 0;
         1: return (k % 2) ? 7 : 0;
         2: return 1 << (k % 3);
         default: return k % 8;
      endcase
   endfunction

   task automatic model_reset();
      m_h1 = 1; m_h2 = 1; m_db = 1; m_run = 0; m_evt = 0;
      m_hold = 0; m_long = 0; m_short = 0;
      m_mode = 0; m_since = 0;
      m_phase = P_HW; m_lock = 0; m_led = 0; m_owner = 0; m_en = 1;
   endtask

   task automatic model_step();
      bit claim, differ, flip, rel, adv;
      int p, n_db, n_run, n_evt, n_hold, n_long, n_short;
      if (rst) begin
         model_reset();
      end else begin
         claim  = req && (ouen[2:0] == 3'b111);
         differ = (m_h2 != m_db);
         flip   = differ && (m_run + 1 == D);
         rel    = flip && (m_db == 0);
         p      = pat_of(m_mode, m_since / B);
         adv    = (m_short != 0) &&
                  ((m_phase == P_HW && !claim) || m_phase == P_LOCK);
         n_evt   = (flip && m_db == 1) ? 1 : 0;
         n_long  = (m_db == 0 && !rel && m_hold == L - 1) ? 1 : 0;
         n_short = (rel && m_hold < L) ? 1 : 0;
         if (rel) n_hold = 0;
         else if (m_db == 0 && m_hold < L) n_hold = m_hold + 1;
         else n_hold = m_hold;
         n_run = (differ && !flip) ? m_run + 1 : 0;
         n_db  = flip ? m_h2 : m_db;
         case (m_phase)
            P_HW: begin
               m_owner = 0;
               if (claim) begin m_phase = P_TOC; m_led = 0; end
               else m_led = p;
            end
            P_TOC: begin m_phase = P_CPU; m_owner = 1; m_led = gpio[2:0]; end
            P_CPU: begin
               if (m_long != 0 || !claim) begin
                  m_phase = P_TOH; m_lock = m_long; m_owner = 0; m_led = 0;
               end else begin
                  m_owner = 1; m_led = gpio[2:0];
               end
            end
            P_TOH: begin
               m_phase = (m_lock != 0) ? P_LOCK : P_HW;
               m_owner = 0; m_led = p;
            end
            default: begin
               m_owner = 0; m_led = p;
               if (!req) m_phase = P_HW;
            end
         endcase
         if (adv) begin m_mode = (m_mode + 1) % 4; m_since = 0; end
         else m_since = m_since + 1;
         m_h2 = m_h1; m_h1 = key;
         m_db = n_db; m_run = n_run; m_evt = n_evt;
         m_hold = n_hold; m_long = n_long; m_short = n_short;
         m_en = 0;
      end
   endtask

   function automatic logic [8:0] mdl_vec();
      return {m_db[0], m_evt[0], m_led[2:0], m_en[0], m_owner[0], m_mode[1:0]};
   endfunction

   function automatic logic [8:0] dut_vec();
      return {key_gpio, key_evt, led, led_en, owner, mode};
   endfunction

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      bit lit;
      rst = 1'b1;
      repeat (3) cyc();
      n_checks++;
      if (dut_vec() !== RST_VEC) begin
         n_errs++;
         $display("FAIL reset_vals got=%b want=%b", dut_vec(), RST_VEC);
      end
      rst = 1'b0;
      cyc();
      n_checks++;
      if (led_en !== 1'b0) begin
         n_errs++;
         $display("FAIL led_en_first got=%b want=0", led_en);
      end
      lit = 0;
      for (int i = 0; i < 24; i++) begin
         cyc();
         if (led !== 3'b000) lit = 1;
         n_checks++;
         if (dut_vec() !== mdl_vec()) begin
            n_errs++;
            $display("FAIL idle_cyc%0d got=%b want=%b", i, dut_vec(), mdl_vec());
         end
      end
      n_checks++;
      if (lit) begin
         n_errs++;
         $display("FAIL mode0_dark got=lit want=000");
      end
   endtask

   task automatic test_debounce();
      int fall, evts, evt_at;
      bit moved;
      fall = -1; evts = 0; evt_at = -1;
      key = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         cyc();
         if (key_gpio === 1'b0 && fall < 0) fall = i;
         if (key_evt === 1'b1) begin evts++; evt_at = i; end
         n_checks++;
         if (dut_vec() !== mdl_vec()) begin
            n_errs++;
            $display("FAIL deb_cyc%0d got=%b want=%b", i, dut_vec(), mdl_vec());
         end
      end
      n_checks++;
      if (fall != D + 2) begin
         n_errs++;
         $display("FAIL deb_latency got=%0d want=%0d", fall, D + 2);
      end
      n_checks++;
      if (evts != 1 || evt_at != D + 2) begin
         n_errs++;
         $display("FAIL press_evt got=%0d@%0d want=1@%0d", evts, evt_at, D + 2);
      end
      key = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         n_checks++;
         if (dut_vec() !== mdl_vec()) begin
            n_errs++;
            $display("FAIL rel_cyc%0d got=%b want=%b", i, dut_vec(), mdl_vec());
         end
      end
      n_checks++;
      if (mode !== 2'd0 || key_gpio !== 1'b1) begin
         n_errs++;
         $display("FAIL long_in_hw got=m%0d k%b want=m0 k1", mode, key_gpio);
      end
      moved = 0; evts = 0;
      for (int i = 0; i < 15; i++) begin
         key = (i < 3) ? 1'b0 : 1'b1;
         cyc();
         if (key_gpio !== 1'b1) moved = 1;
         if (key_evt === 1'b1) evts++;
      end
      n_checks++;
      if (moved || evts != 0) begin
         n_errs++;
         $display("FAIL glitch got=moved%0d evt%0d want=0 0", moved, evts);
      end
   endtask

   task automatic test_modes();
      logic [7:0] masks [4];
      logic [7:0] seen;
      masks[0] = 8'h01; masks[1] = 8'h81; masks[2] = 8'h16; masks[3] = 8'hFF;
      for (int p = 0; p < 5; p++) begin
         seen = 8'h00;
         for (int i = 0; i < 100; i++) begin
            key = (i < 10) ? 1'b0 : 1'b1;
            cyc();
            if (i >= 30) seen[led] = 1'b1;
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
               n_errs++;
               $display("FAIL mode_p%0d_c%0d got=%b want=%b", p, i, dut_vec(), mdl_vec());
            end
         end
         n_checks++;
         if (mode !== 2'((p + 1) % 4)) begin
            n_errs++;
            $display("FAIL mode_adv%0d got=%0d want=%0d", p, mode, (p + 1) % 4);
         end
         n_checks++;
         if (seen !== masks[(p + 1) % 4]) begin
            n_errs++;
            $display("FAIL pat_set%0d got=%h want=%h", p, seen, masks[(p + 1) % 4]);
         end
      end
   endtask

   task automatic test_cpu_claim();
      int evts;
      evts = 0;
      ouen = 16'h0007; gpio = 16'h0005; req = 1'b1;
      for (int i = 0; i < 40; i++) begin
         key = (i >= 10 && i < 20) ? 1'b0 : 1'b1;
         if (i == 30) gpio = 16'h0003;
         cyc();
         if (key_evt === 1'b1) evts++;
         if (i == 0) begin
            n_checks++;
            if (led !== 3'b000 || owner !== 1'b0) begin
               n_errs++;
               $display("FAIL claim_blank got=%b/%b want=000/0", led, owner);
            end
         end
         if (i == 1) begin
            n_checks++;
            if (led !== 3'b101 || owner !== 1'b1) begin
               n_errs++;
               $display("FAIL claim_own got=%b/%b want=101/1", led, owner);
            end
         end
         n_checks++;
         if (dut_vec() !== mdl_vec()) begin
            n_errs++;
            $display("FAIL cpu_cyc%0d got=%b want=%b", i, dut_vec(), mdl_vec());
         end
      end
      n_checks++;
      if (evts != 1 || mode !== 2'd1 || led !== 3'b011) begin
         n_errs++;
         $display("FAIL cpu_press got=e%0d m%0d l%b want=e1 m1 l011", evts, mode, led);
      end
   endtask

   task automatic test_long_lock();
      int off_at, own_at;
      bit blank_ok;
      off_at = -1; blank_ok = 0;
      for (int i = 0; i < 70; i++) begin
         key = (i < 30) ? 1'b0 : 1'b1;
         cyc();
         if (owner === 1'b0 && off_at < 0) begin
            off_at = i;
            blank_ok = (led === 3'b000);
         end
         n_checks++;
         if (dut_vec() !== mdl_vec()) begin
            n_errs++;
            $display("FAIL long_cyc%0d got=%b want=%b", i, dut_vec(), mdl_vec());
         end
      end
      n_checks++;
      if (off_at < 0 || !blank_ok) begin
         n_errs++;
         $display("FAIL long_g2h got=at%0d blank%0d want=blank1", off_at, blank_ok);
      end
      n_checks++;
      if (owner !== 1'b0 || mode !== 2'd1) begin
         n_errs++;
         $display("FAIL lock_hold got=o%b m%0d want=o0 m1", owner, mode);
      end
      own_at = -1;
      for (int j = 0; j < 10; j++) begin
         req = (j == 0) ? 1'b0 : 1'b1;
         cyc();
         if (owner === 1'b1 && own_at < 0) own_at = j;
         n_checks++;
         if (dut_vec() !== mdl_vec()) begin
            n_errs++;
            $display("FAIL relock_cyc%0d got=%b want=%b", j, dut_vec(), mdl_vec());
         end
      end
      n_checks++;
      if (own_at != 2) begin
         n_errs++;
         $display("FAIL reclaim got=%0d want=2", own_at);
      end
   endtask

   task automatic test_reset_mid();
      key = 1'b0;
      for (int i = 0; i < 15; i++) begin
         cyc();
         n_checks++;
         if (dut_vec() !== mdl_vec()) begin
            n_errs++;
            $display("FAIL rmid_cyc%0d got=%b want=%b", i, dut_vec(), mdl_vec());
         end
      end
      rst = 1'b1;
      cyc();
      n_checks++;
      if (dut_vec() !== RST_VEC) begin
         n_errs++;
         $display("FAIL reset_mid got=%b want=%b", dut_vec(), RST_VEC);
      end
      rst = 1'b0; key = 1'b1;
      for (int i = 0; i < 30; i++) begin
         cyc();
         n_checks++;
         if (dut_vec() !== mdl_vec()) begin
            n_errs++;
            $display("FAIL post_rst%0d got=%b want=%b", i, dut_vec(), mdl_vec());
         end
      end
      n_checks++;
      if (owner !== 1'b1 || mode !== 2'd0) begin
         n_errs++;
         $display("FAIL post_rst_own got=o%b m%0d want=o1 m0", owner, mode);
      end
   endtask

   task automatic test_random();
      int run_left, shown;
      run_left = 0; shown = 0;
      for (int i = 0; i < 4000; i++) begin
         if (run_left == 0) begin
            key = ~key;
            run_left = $urandom_range(1, 40);
         end else begin
            run_left--;
         end
         if ($urandom_range(0, 39) == 0) req = ~req;
         if ($urandom_range(0, 49) == 0) ouen = 16'($urandom);
         else if ($urandom_range(0, 19) == 0) ouen = 16'h0007;
         if ($urandom_range(0, 3) == 0) gpio = 16'($urandom);
         rst = ($urandom_range(0, 799) == 0);
         cyc();
         n_checks++;
         if (dut_vec() !== mdl_vec()) begin
            n_errs++;
            if (shown < 20) begin
               shown++;
               $display("FAIL rand_cyc%0d got=%b want=%b", i, dut_vec(), mdl_vec());
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_debounce();
      test_modes();
      test_cpu_claim();
      test_long_lock();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/led_owner_arb.md
Name: led_owner_arb

Overview:
- Sequences the board LEDs and the user key between two sources: the EMPU GPIO port (CPU software) and an on-fabric pattern generator.
- Debounces the raw key and forwards a clean level to the EMPU GPIO input.
- Decides, cycle by cycle, who drives the 3 LEDs, with a blanking guard on every ownership change.
- Sits between top-level pins and the EMPU GPIO bus.

Parameters:
- DEBOUNCE_CYC, 540000, consecutive stable cycles required to accept a key level change (20 ms at 27 MHz).
- LONG_CYC, 54000000, debounced-pressed cycles that qualify as a long press (2 s).
- BLINK_CYC, 13500000, pattern step period in cycles (0.5 s).

Ports:
- sys_clk_i  in  1  system clock, sole clock domain.
- reset_i  in  1  synchronous reset, active high.
- key_i  in  1  raw key pin, active low, asynchronous.
- cpu_gpioout_i  in  16  EMPU gpioout; bits [2:0] are the CPU LED values.
- cpu_gpioouten_i  in  16  EMPU gpioouten; bits [2:0] must all be 1 for a CPU claim.
- cpu_req_i  in  1  CPU request for LED ownership (level).
- key_gpio_o  out  1  debounced key level to EMPU gpioin; 1 = released.
- key_evt_o  out  1  one-cycle pulse on debounced press.
- led_o  out  3  LED drive, 1 = on.
- led_en_o  out  1  LED bank enable, active low.
- owner_o  out  1  0 = hardware pattern, 1 = CPU.
- mode_o  out  2  current hardware pattern.

Behaviour:
- Reset values: key_gpio_o=1, key_evt_o=0, led_o=000, led_en_o=1, owner_o=0, mode_o=0. All counters are 0 and the FSM is in HW.
- led_en_o goes to 0 on the first cycle after reset deasserts and stays 0.
- Key sync and debounce:
  - key_i passes through a 2-flop synchronizer.
  - A counter increments while the synchronizer output differs from key_db and clears otherwise.
  - When the counter reaches DEBOUNCE_CYC, key_db takes the new value and the counter clears.
  - A clean key_i edge therefore reaches key_gpio_o exactly DEBOUNCE_CYC+2 cycles later.
  - Glitches shorter than DEBOUNCE_CYC never change key_db.
- key_evt_o pulses for 1 cycle in the cycle key_db goes 1->0, regardless of owner.
- Hold counter:
  - Counts while key_db=0 and saturates at LONG_CYC.
  - Reaching LONG_CYC raises long_evt once per press.
  - On release (key_db 0->1) with hold<LONG_CYC, short_evt is raised. The hold counter clears on release.
- Pattern generator:
  - A tick counter runs 0..BLINK_CYC-1 and wraps; the tick fires on the wrap.
  - mode 0 OFF: pattern 000.
  - mode 1 BLINK: 000/111, toggling each tick.
  - mode 2 CHASE: 001->010->100->001, advancing each tick.
  - mode 3 COUNT: 3-bit up count 000..111, then 000.
  - A mode change clears the tick counter and loads the first pattern value (000, 000, 001, 000) in the same cycle.
- Mode control:
  - short_evt while owner=HW advances mode_o (3 wraps to 0).
  - short_evt while owner=CPU does not change the mode.
- Owner FSM, evaluated every cycle:
  - HW: owner_o=0, led_o=pattern. Leaves when cpu_req_i=1 and cpu_gpioouten_i[2:0]=111 -> G2C.
  - G2C: led_o=000 for one cycle -> CPU.
  - CPU: owner_o=1, led_o=cpu_gpioout_i[2:0], registered with 1-cycle latency.
    - cpu_req_i=0 or gpioouten[2:0]!=111 -> G2H.
    - long_evt -> G2H with lockout flagged.
  - G2H: led_o=000 for one cycle. Goes to LOCK if lockout is flagged, else HW.
  - LOCK: owner_o=0, led_o=pattern. Ignores cpu_req_i until it has been seen 0 for at least one cycle, then -> HW.
- Simultaneous events:
  - long_evt wins over any CPU claim in the same cycle.
  - long_evt in HW or LOCK has no effect.
  - A short_evt coinciding with a transition into CPU is dropped.
- led_o is registered and never glitches between sources; guard cycles are always 000.
- reset_i mid-operation returns all state to the reset values on the next edge, including a press in progress.

Test Plan (DEBOUNCE_CYC=4, LONG_CYC=20, BLINK_CYC=8):
- Reset, hold key_i=1 -> led_en_o=0 from cycle 1; mode 0 keeps led_o=000; tick wraps every 8 cycles.
- key_i 1->0 clean -> key_gpio_o falls at +6 cycles with one key_evt_o pulse. A 3-cycle low glitch -> no change and no pulse.
- Short press (10 cycles low) then release, in HW -> mode_o 0->1; led_o toggles 000/111 every 8 cycles. Three more presses -> mode 2 chase 001,010,100, then mode 3, then wrap to 0.
- gpioouten=0x0007, cpu_gpioout=0x0005, cpu_req_i=1 -> one cycle led_o=000, then owner_o=1, led_o=101. Short press -> key_evt_o pulses and mode_o is unchanged.
- In CPU, hold key 30 cycles -> G2H blank cycle, owner_o=0, pattern resumes; cpu_req_i held at 1 is ignored. Pulse cpu_req_i 0 then 1 -> reclaim via G2C.
- Assert reset_i while the key is held and in CPU -> next edge gives all outputs at reset values, owner_o=0, mode_o=0.
